mix_i2s_tx: RTL and testbench
=============================

# mix_i2s_tx

Audio output stage directly downstream of `Mixer16`. Takes the 20-bit unsigned 16-voice sum and recentres it to signed. Applies a power-of-two gain, saturates to 16-bit signed and serialises the result as a mono-duplicated I2S stream to the DAC. It also issues a per-frame sample strobe so the upstream oscillators can advance exactly once per output sample.

## Interface
- `CLK_DIV`, default 8: `clk` cycles per half BCLK period; minimum 2. BCLK = f_clk / (2·CLK_DIV); frame rate = BCLK / 32.
- `clk` input, 1 bit: single system clock; all logic on its rising edge.
- `rst_n` input, 1 bit: asynchronous active-low reset.
- `enable` input, 1 bit: high runs the serialiser; low holds it idle.
- `mixed_signal` input, 20 bits: unsigned sum from `Mixer16`, range 0..0xFFFF0.
- `gain_shift` input, 3 bits: left-shift amount 0..4; values 5..7 are treated as 4.
- `bclk` output, 1 bit: I2S bit clock.
- `lrclk` output, 1 bit: word select; 0 = left, 1 = right.
- `sdata` output, 1 bit: I2S serial data, MSB first.
- `sample_strobe` output, 1 bit: one-`clk` pulse when a new sample word is loaded.
- `clip` output, 1 bit: high for the whole frame whose word was saturated.

## Operation
- **Recentre.** Compute `s = mixed_signal − 0x80000` as 20-bit signed. This is equivalent to inverting bit 19. Range is −524288..+524272.
- **Scale.** Compute `t = s << g` in 24-bit signed, where g = min(gain_shift, 4). The output word is `t >>> 4` saturated to −32768..+32767.
- **Clip flag.** Set the clip flag when saturation alters the value.
- **Stage-1 register.** Updates every `clk` with the saturated word and its clip flag. There is no handshake on `mixed_signal`; it is sampled continuously.
- **Divider.** `div_cnt` counts 0..CLK_DIV−1. When `div_cnt` = CLK_DIV−1, `bclk` toggles and `div_cnt` wraps to 0.
- **Bit counter.** On every BCLK falling edge (the toggle 1→0), `bit_cnt` advances 0..31 and wraps.
  - When `bit_cnt` wraps 31→0, a 32-bit shift register loads {word, word} from stage 1. On the same `clk`, `sample_strobe` = 1 and `clip` is updated from stage 1.
  - `sdata` = shift register MSB. The register shifts left one bit on each later falling edge.
  - `lrclk` changes on the falling edge that sets `bit_cnt` = 31 (to 0) and `bit_cnt` = 15 (to 1). This gives standard I2S one-BCLK word-select lead.
- **Disable.** `enable` low, sampled on any `clk`, forces `div_cnt` = 0, `bclk` = 0, `bit_cnt` = 31, `lrclk` = 0, `sdata` = 0 and `sample_strobe` = 0 on the next edge, even mid-frame. `clip` holds its value. Re-enable restarts from frame start with no partial frame.
- **Reset.** Reset asserted at any time forces the same idle state with `clip` = 0, shift register = 0 and stage 1 = 0.

## Timing
- Reset/idle values: `bclk` 0, `lrclk` 0, `sdata` 0, `sample_strobe` 0, `clip` 0.
- **First edges.** After `rst_n` deasserts with `enable` high:
  - the first `bclk` rise occurs on the CLK_DIV-th `clk` edge;
  - the first fall and the first `sample_strobe` occur on the 2·CLK_DIV-th edge.
- **Latency.** A value on `mixed_signal` before edge N is in stage 1 after edge N. A load at edge M uses the stage-1 value from edge M−1. The word's MSB appears on `sdata` at the load edge.
- **Strobe period.** `sample_strobe` period is exactly 64·CLK_DIV `clk` cycles.
- **Data alignment.** `sdata` changes only on BCLK falling edges, so it is stable across each rising edge.
- **Gain changes.** A change to `gain_shift` affects only words loaded at or after the next load edge.

## Structure
- Shared package `synth_pkg`:
  - `MIX_W` = 20, `SAMPLE_W` = 16, `MIX_OFFSET` = 20'h80000, `MAX_GAIN` = 4;
  - a saturating function `sat16(logic signed [23:0])`.
- One sub-module, `gain_sat`: the combinational recentre/shift/saturate plus the stage-1 register and clip output. The top level holds the divider, counters and shift register.

## Test plan
- **Centre word.** CLK_DIV=2, gain 0, mixed 0x80000 → left and right words 0x0000, `clip` 0; `sample_strobe` every 128 `clk`.
- **Full scale.** Gain 0: mixed 0xFFFF0 → 0x7FFF; mixed 0x00000 → 0x8000; `clip` 0 for both.
- **Gain and saturation.**
  - Gain 2, mixed 0x84000 → 0x1000.
  - Gain 4, mixed 0x90000 → 0x7FFF with `clip` 1 for that frame.
  - Gain 7 behaves as 4.
- **I2S framing.** Decode `sdata` on `bclk` rises, constant mixed 0xA5A50, gain 0 → 0x25A5 in both channels. `lrclk` toggles one BCLK before each MSB; 16 bits per channel.
- **Disable mid-frame.** `enable` low at `bit_cnt` 7 → idle values next edge. Re-enable → first `sample_strobe` after 2·CLK_DIV cycles and a complete frame.
- **Reset mid-frame.** Assert `rst_n` low asynchronously mid-frame → all outputs at reset values immediately with no `clk` edge; restart timing matches the reset-release case.

Source files
------------

// File: rtl/synth_pkg.sv
// Shared constants and helpers for the mixer audio output path.
// Latency: none (declarations and a combinational function only).
// Backpressure: none.
package synth_pkg;

  localparam int MIX_W    = 20;
  localparam int SAMPLE_W = 16;
  localparam int MAX_GAIN = 4;
  localparam logic [MIX_W-1:0] MIX_OFFSET = 20'h80000;

  // Clamp a wide signed value into the 16-bit signed sample range
  function automatic logic signed [SAMPLE_W-1:0] sat16(input logic signed [23:0] x);
    if (x > 24'sd32767) begin
      return 16'sh7FFF;
    end else if (x < -24'sd32768) begin
      return 16'sh8000;
    end else begin
      return x[SAMPLE_W-1:0];
    end
  endfunction

endpackage

// File: rtl/gain_sat.sv
// Recentre the unsigned mixer sum, apply power-of-two gain, saturate to 16 bits.
// Latency: 1 clk (stage-1 register, updated every cycle).
// Backpressure: none; the input is sampled continuously.
module gain_sat
  import synth_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [MIX_W-1:0]    mixed_signal,
  input  logic [2:0]          gain_shift,
  output logic [SAMPLE_W-1:0] word,
  output logic                clip_flag
);

  logic        [2:0]          gain;
  logic signed [MIX_W-1:0]    centred;
  logic signed [23:0]         scaled;
  logic signed [23:0]         reduced;
  logic signed [SAMPLE_W-1:0] sat_word;
  logic                       sat_hit;

  // Recentre (same as flipping bit 19), scale, drop 4 fractional bits, saturate
  always_comb begin
    gain     = (gain_shift > 3'(MAX_GAIN)) ? 3'(MAX_GAIN) : gain_shift;
    centred  = mixed_signal - MIX_OFFSET;
    scaled   = {{4{centred[MIX_W-1]}}, centred} <<< gain;
    reduced  = scaled >>> 4;
    sat_word = sat16(reduced);
    sat_hit  = (reduced != {{8{sat_word[SAMPLE_W-1]}}, sat_word});
  end

  // Stage-1 register: refreshed every clk with the word and its clip flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word      <= '0;
      clip_flag <= 1'b0;
    end else begin
      word      <= sat_word;
      clip_flag <= sat_hit;
    end
  end

endmodule

// File: rtl/mix_i2s_tx.sv
// Mono-duplicated I2S transmitter fed from the 16-voice mixer sum.
// Latency: 1 clk into stage 1, word MSB on sdata at the next frame-start BCLK fall.
// Backpressure: none; frames free-run while enable is high, one strobe per frame.
module mix_i2s_tx
  import synth_pkg::*;
#(
  parameter int CLK_DIV = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [MIX_W-1:0] mixed_signal,
  input  logic [2:0]       gain_shift,
  output logic             bclk,
  output logic             lrclk,
  output logic             sdata,
  output logic             sample_strobe,
  output logic             clip
);

  localparam int DIV_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  logic [DIV_W-1:0]    div_cnt;
  logic [4:0]          bit_cnt;
  logic [31:0]         shreg;
  logic [SAMPLE_W-1:0] word;
  logic                word_clip;
  logic                div_wrap;
  logic                bclk_fall;
  logic                frame_start;

  gain_sat u_gain_sat (
    .clk          (clk),
    .rst_n        (rst_n),
    .mixed_signal (mixed_signal),
    .gain_shift   (gain_shift),
    .word         (word),
    .clip_flag    (word_clip)
  );

  assign div_wrap    = (div_cnt == DIV_W'(CLK_DIV - 1));
  assign bclk_fall   = div_wrap && bclk;
  assign frame_start = bclk_fall && (bit_cnt == 5'd31);
  assign sdata       = shreg[31];

  // Bit-clock divider: toggle bclk every CLK_DIV cycles, parked low when disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (!enable) begin
      div_cnt <= '0;
      bclk    <= 1'b0;
    end else if (div_wrap) begin
      div_cnt <= '0;
      bclk    <= ~bclk;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Framing: bit counter, word select, shift register, strobe and frame clip flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt       <= 5'd31;
      lrclk         <= 1'b0;
      shreg         <= '0;
      sample_strobe <= 1'b0;
      clip          <= 1'b0;
    end else if (!enable) begin
      // Idle parks at bit 31 so the first fall after re-enable starts a frame
      bit_cnt       <= 5'd31;
      lrclk         <= 1'b0;
      shreg         <= '0;
      sample_strobe <= 1'b0;
    end else begin
      sample_strobe <= frame_start;
      if (bclk_fall) begin
        bit_cnt <= bit_cnt + 5'd1;
        if (frame_start) begin
          shreg <= {word, word};
          clip  <= word_clip;
        end else begin
          shreg <= {shreg[30:0], 1'b0};
        end
        // Word select leads each channel MSB by one BCLK
        if (bit_cnt == 5'd30) begin
          lrclk <= 1'b0;
        end else if (bit_cnt == 5'd14) begin
          lrclk <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mix_i2s_tx.sv
// Randomized and directed bench for mix_i2s_tx against a frame-level reference model.
// Checks every clk: bclk, lrclk, sdata, sample_strobe, clip; decodes whole frames too.
// Covers reset, disable mid-frame, asynchronous reset mid-frame and gain saturation.
module tb_mix_i2s_tx;

  localparam int D    = 2;
  localparam int HMAX = 8192;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [19:0] mixed_signal = '0;
  logic [2:0]  gain_shift = '0;
  logic        bclk, lrclk, sdata, sample_strobe, clip;

  always #5 clk = ~clk;

  mix_i2s_tx #(.CLK_DIV(D)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .mixed_signal  (mixed_signal),
    .gain_shift    (gain_shift),
    .bclk          (bclk),
    .lrclk         (lrclk),
    .sdata         (sdata),
    .sample_strobe (sample_strobe),
    .clip          (clip)
  );

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n       = 0;
  logic        running  = 1'b0;
  logic        rand_mode = 1'b1;
  logic        dir_mode  = 1'b0;
  logic [15:0] dir_word  = '0;
  logic        exp_clip  = 1'b0;
  logic [31:0] cap       = '0;
  logic [19:0] hm [HMAX];
  logic [2:0]  hg [HMAX];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at n=%0d: got %0h expected %0h", tag, n, got, exp);
    end
  endtask

  // Spec arithmetic: subtract offset, multiply by 2^g, floor-divide by 16
  function automatic int ref_val(input logic [19:0] m, input logic [2:0] g);
    int s;
    int gg;
    s  = int'({12'd0, m}) - 524288;
    gg = (g > 3'd4) ? 4 : int'(g);
    return (s * (1 << gg)) >>> 4;
  endfunction

  function automatic logic [15:0] ref_word(input logic [19:0] m, input logic [2:0] g);
    int v;
    v = ref_val(m, g);
    if (v > 32767) v = 32767;
    if (v < -32768) v = -32768;
    return v[15:0];
  endfunction

  function automatic logic ref_clip(input logic [19:0] m, input logic [2:0] g);
    int v;
    v = ref_val(m, g);
    return (v > 32767) || (v < -32768);
  endfunction

  task automatic model_check();
    int          j, k, m_edge;
    logic        e_bclk, e_stb, e_sd, e_lr;
    logic [15:0] w;
    e_bclk = ((n / D) % 2) == 1;
    e_stb  = (n >= 2*D) && (((n - 2*D) % (64*D)) == 0);
    e_sd   = 1'b0;
    e_lr   = 1'b0;
    k      = 0;
    j      = n / (2*D);
    if (j >= 1) begin
      k      = (j - 1) % 32;
      m_edge = 2*D*(((j - 1) / 32) * 32 + 1);
      w      = ref_word(hm[m_edge-1], hg[m_edge-1]);
      if (n == m_edge) exp_clip = ref_clip(hm[m_edge-1], hg[m_edge-1]);
      e_sd = w[15 - (k % 16)];
      e_lr = (k >= 15) && (k <= 30);
    end
    check("bclk", bclk, e_bclk);
    check("strobe", sample_strobe, e_stb);
    check("sdata", sdata, e_sd);
    check("lrclk", lrclk, e_lr);
    check("clip", clip, exp_clip);
    // Frame decode on bclk rises
    if (j >= 1 && e_bclk && (n % D) == 0) begin
      cap = {cap[30:0], sdata};
      if (dir_mode && k == 31) check("frame", cap, {dir_word, dir_word});
    end
  endtask

  task automatic idle_check();
    check("idle_bclk", bclk, 1'b0);
    check("idle_lrclk", lrclk, 1'b0);
    check("idle_sdata", sdata, 1'b0);
    check("idle_strobe", sample_strobe, 1'b0);
    check("idle_clip", clip, exp_clip);
  endtask

  task automatic step();
    if (rand_mode) begin
      mixed_signal = 20'($urandom_range(0, 20'hFFFF0));
      gain_shift   = 3'($urandom_range(0, 7));
    end
    if (running && n + 1 < HMAX) begin
      hm[n+1] = mixed_signal;
      hg[n+1] = gain_shift;
    end
    @(posedge clk);
    #1;
    if (running) begin
      n++;
      model_check();
    end else begin
      idle_check();
    end
  endtask

  task automatic start();
    enable  = 1'b1;
    running = 1'b1;
    n       = 0;
  endtask

  task automatic stop();
    enable  = 1'b0;
    running = 1'b0;
    step();
  endtask

  task automatic directed(input logic [19:0] m, input logic [2:0] g,
                          input logic [15:0] w, input logic c);
    stop();
    step();
    rand_mode    = 1'b0;
    mixed_signal = m;
    gain_shift   = g;
    dir_word     = w;
    dir_mode     = 1'b1;
    start();
    for (int i = 0; i < 2*64*D + 4; i++) begin
      step();
      if (n == 2*D) check("dir_clip", clip, c);
    end
    dir_mode  = 1'b0;
    rand_mode = 1'b1;
  endtask

  initial begin
    // Reset state
    for (int i = 0; i < 3; i++) step();
    // Release reset with enable high, random traffic for three frames
    rst_n = 1'b1;
    start();
    for (int i = 0; i < 3*64*D; i++) step();

    // Disable mid-frame at bit 7, then re-enable
    begin
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < 64*D && !hit; i++) begin
        if (n >= 2*D && (((n / (2*D)) - 1) % 32) == 7) hit = 1'b1;
        else step();
      end
      check("dis_reach", hit, 1'b1);
    end
    stop();
    for (int i = 0; i < 4; i++) step();
    start();
    for (int i = 0; i < 64*D + 40; i++) step();

    // Asynchronous reset mid-frame: outputs clear with no clk edge
    #2;
    rst_n = 1'b0;
    #1;
    exp_clip = 1'b0;
    running  = 1'b0;
    check("arst_bclk", bclk, 1'b0);
    check("arst_lrclk", lrclk, 1'b0);
    check("arst_sdata", sdata, 1'b0);
    check("arst_strobe", sample_strobe, 1'b0);
    check("arst_clip", clip, 1'b0);
    for (int i = 0; i < 3; i++) step();
    rst_n = 1'b1;
    start();
    for (int i = 0; i < 2*64*D; i++) step();

    // Directed words from the test plan
    directed(20'h80000, 3'd0, 16'h0000, 1'b0);
    directed(20'hFFFF0, 3'd0, 16'h7FFF, 1'b0);
    directed(20'h00000, 3'd0, 16'h8000, 1'b0);
    directed(20'h84000, 3'd2, 16'h1000, 1'b0);
    directed(20'h90000, 3'd4, 16'h7FFF, 1'b1);
    // clip must hold through idle
    stop();
    check("clip_hold", clip, 1'b1);
    directed(20'h90000, 3'd7, 16'h7FFF, 1'b1);
    directed(20'hA5A50, 3'd0, 16'h25A5, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
